// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin arbiter requester agents.
package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [NUM_REQ-1:0] req_onehot_t;

    localparam int ARB_DATA_W  = 8;
    localparam int ARB_DEPTH   = 4;
    localparam int ARB_TIMEOUT = 15;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. DEPTH must be a power of two so the
// pointers wrap naturally. Push when full and pop when empty are ignored.
module sync_fifo
    import arb_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W,
    parameter int DEPTH  = ARB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset since pointers and count gate reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/arb_requester.sv
// Client-side agent for one arbiter port: buffers producer words, raises a
// registered request while work is pending and issues one word per grant.
// Optional starvation monitor enabled by defining ARB_REQ_STARVE_EN; without
// it, starve is tied low.
module arb_requester
    import arb_pkg::*;
#(
    parameter int DATA_W  = ARB_DATA_W,
    parameter int DEPTH   = ARB_DEPTH,
    parameter int TIMEOUT = ARB_TIMEOUT,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              request,
    input  logic              grant,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic              spurious,
    output logic              starve
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("arb_requester: DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("arb_requester: TIMEOUT must be at least 1");
    end

    logic [DATA_W-1:0] rd_data;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count_next;

    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = grant && !empty;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (in_data),
        .rd_data (rd_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Occupancy after this edge, so request tracks the FIFO without a cycle of lag.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Request register, issue strobe/data and the sticky spurious-grant flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            request   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            spurious  <= 1'b0;
        end else begin
            request   <= (count_next != '0);
            out_valid <= pop;
            if (pop) begin
                out_data <= rd_data;
            end
            // A grant on an empty FIFO (including the same edge as a push) is audited.
            if (grant && empty) begin
                spurious <= 1'b1;
            end
        end
    end

`ifdef ARB_REQ_STARVE_EN
    localparam int SC_W = $clog2(TIMEOUT + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(TIMEOUT);

    logic [SC_W-1:0] starve_cnt;
    logic [SC_W-1:0] starve_cnt_next;

    // Count cycles of unanswered request, saturating at TIMEOUT.
    always_comb begin
        starve_cnt_next = starve_cnt;
        if (grant || !request) begin
            starve_cnt_next = '0;
        end else if (starve_cnt != SC_MAX) begin
            starve_cnt_next = starve_cnt + SC_W'(1);
        end
    end

    // Flag flop mirrors the counter so starve equals (counter == TIMEOUT) each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            starve     <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_next;
            starve     <= (starve_cnt_next == SC_MAX);
        end
    end
`else
    assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_arb_requester;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              request;
    logic              grant;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  count;
    logic              spurious;
    logic              starve;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DATA_W-1:0] m_q [$];
    logic              m_request;
    logic              m_out_valid;
    logic [DATA_W-1:0] m_out_data;
    logic              m_spurious;
    int                m_wait;
    logic              m_starve;

    arb_requester #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .request   (request),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (count),
        .spurious  (spurious),
        .starve    (starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented at that edge.
    task automatic model_edge();
        bit acc_push;
        bit acc_pop;
        logic req_before;
        req_before = m_request;
        if (reset) begin
            m_q.delete();
            m_request   = 1'b0;
            m_out_valid = 1'b0;
            m_out_data  = '0;
            m_spurious  = 1'b0;
            m_wait      = 0;
            m_starve    = 1'b0;
            return;
        end
        acc_push = in_valid && (m_q.size() < DEPTH);
        acc_pop  = grant && (m_q.size() > 0);
        if (grant && m_q.size() == 0) m_spurious = 1'b1;
        m_out_valid = acc_pop;
        if (acc_pop) m_out_data = m_q.pop_front();
        if (acc_push) m_q.push_back(in_data);
        m_request = (m_q.size() != 0);
        if (grant || !req_before) m_wait = 0;
        else if (m_wait < TIMEOUT) m_wait++;
`ifdef ARB_REQ_STARVE_EN
        m_starve = (m_wait == TIMEOUT);
`else
        m_starve = 1'b0;
`endif
    endtask

    task automatic compare_all();
        chk("request", 32'(request), 32'(m_request));
        chk("count", 32'(count), 32'(m_q.size()));
        chk("in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
        chk("out_valid", 32'(out_valid), 32'(m_out_valid));
        if (m_out_valid) chk("out_data", 32'(out_data), 32'(m_out_data));
        chk("spurious", 32'(spurious), 32'(m_spurious));
        chk("starve", 32'(starve), 32'(m_starve));
    endtask

    // One clock cycle: drive, clock, update model, sample on the falling edge.
    task automatic cyc(input logic r, input logic v, input logic [DATA_W-1:0] d, input logic g);
        reset    = r;
        in_valid = v;
        in_data  = d;
        grant    = g;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    int gp;
    int gp_tab [6] = '{50, 10, 90, 2, 70, 30};

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; grant = 1'b0;
        m_q.delete(); m_request = 0; m_out_valid = 0; m_out_data = 0;
        m_spurious = 0; m_wait = 0; m_starve = 0;

        // Reset with a grant present: must not set spurious
        cyc(1, 0, 8'h00, 1);
        cyc(1, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 0);
        chk("idle_request", 32'(request), 0);
        chk("idle_in_ready", 32'(in_ready), 1);
        chk("idle_spurious", 32'(spurious), 0);

        // Three pushes then three grants
        cyc(0, 1, 8'hA1, 0);
        chk("req_after_first_push", 32'(request), 1);
        cyc(0, 1, 8'hB2, 0);
        cyc(0, 1, 8'hC3, 0);
        chk("count_three", 32'(count), 3);
        cyc(0, 0, 8'h00, 1);
        chk("pop_a1", 32'(out_data), 32'h A1);
        cyc(0, 0, 8'h00, 1);
        chk("pop_b2", 32'(out_data), 32'h B2);
        cyc(0, 0, 8'h00, 1);
        chk("pop_c3", 32'(out_data), 32'h C3);
        chk("req_after_last_pop", 32'(request), 0);
        cyc(0, 0, 8'h00, 0);

        // Fill, overflow attempt, drain in order
        cyc(0, 1, 8'h11, 0);
        cyc(0, 1, 8'h22, 0);
        cyc(0, 1, 8'h33, 0);
        cyc(0, 1, 8'h44, 0);
        chk("full_in_ready", 32'(in_ready), 0);
        cyc(0, 1, 8'hFF, 0);
        chk("full_count", 32'(count), 4);
        cyc(0, 0, 8'h00, 1); chk("drain_11", 32'(out_data), 32'h11);
        cyc(0, 0, 8'h00, 1); chk("drain_22", 32'(out_data), 32'h22);
        cyc(0, 0, 8'h00, 1); chk("drain_33", 32'(out_data), 32'h33);
        cyc(0, 0, 8'h00, 1); chk("drain_44", 32'(out_data), 32'h44);

        // Simultaneous push and pop at count 2
        cyc(0, 1, 8'h66, 0);
        cyc(0, 1, 8'h77, 0);
        cyc(0, 1, 8'h55, 1);
        chk("simul_count", 32'(count), 2);
        chk("simul_pop_66", 32'(out_data), 32'h66);
        cyc(0, 0, 8'h00, 1); chk("simul_pop_77", 32'(out_data), 32'h77);
        cyc(0, 0, 8'h00, 1); chk("simul_pop_55", 32'(out_data), 32'h55);
        chk("spurious_before", 32'(spurious), 0);

        // Trailing grant after last pop
        cyc(0, 0, 8'h00, 1);
        chk("trailing_out_valid", 32'(out_valid), 0);
        chk("trailing_spurious", 32'(spurious), 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 0);
        chk("spurious_sticky", 32'(spurious), 1);
        cyc(1, 0, 8'h00, 1);
        chk("spurious_cleared", 32'(spurious), 0);

        // Starvation: one word, no grant for TIMEOUT cycles
        cyc(0, 1, 8'h9C, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) cyc(0, 0, 8'h00, 0);
        chk("starve_not_yet", 32'(starve), 0);
        cyc(0, 0, 8'h00, 0);
`ifdef ARB_REQ_STARVE_EN
        chk("starve_set", 32'(starve), 1);
`else
        chk("starve_tied_low", 32'(starve), 0);
`endif
        cyc(0, 0, 8'h00, 1);
        chk("starve_cleared", 32'(starve), 0);
        chk("starve_pop_9c", 32'(out_data), 32'h9C);

        // Randomized traffic with varying grant density and occasional resets
        for (int i = 0; i < 3000; i++) begin
            gp = gp_tab[(i / 500) % 6];
            cyc(($urandom_range(0, 249) == 0),
                ($urandom_range(0, 99) < 60),
                DATA_W'($urandom),
                ($urandom_range(0, 99) < gp));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
